// File: rtl/light_timer_pkg.sv
// Shared codes, defaults and FSM states for the light interval timer.
package light_timer_pkg;

  localparam logic [2:0] IV_BASE = 3'd0;
  localparam logic [2:0] IV_DBL  = 3'd1;
  localparam logic [2:0] IV_EXT  = 3'd2;
  localparam logic [2:0] IV_YEL  = 3'd3;

  localparam logic [1:0] PS_BASE = 2'd0;
  localparam logic [1:0] PS_EXT  = 2'd1;
  localparam logic [1:0] PS_YEL  = 2'd2;

  localparam logic [3:0] DEF_TB = 4'd6;
  localparam logic [3:0] DEF_TE = 4'd3;
  localparam logic [3:0] DEF_TY = 4'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  function automatic logic [4:0] sel_len(
    input logic [2:0] iv,
    input logic [3:0] tb,
    input logic [3:0] te,
    input logic [3:0] ty
  );
    logic [4:0] len;
    len = {1'b0, tb};
    case (iv)
      IV_DBL:  len = {tb, 1'b0};
      IV_EXT:  len = {1'b0, te};
      IV_YEL:  len = {1'b0, ty};
      default: len = {1'b0, tb};
    endcase
    return len;
  endfunction

endpackage

// File: rtl/light_timer_tick_prescaler.sv
// Divides clk down to a one-cycle tick every TICK_DIV cycles.
// Held at zero while clear is high.
module tick_prescaler #(
  parameter int TICK_DIV = 100000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] TERM = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;

  assign tick = !clear && (cnt_q == TERM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else if (clear || tick)
      cnt_q <= '0;
    else
      cnt_q <= cnt_q + CW'(1);
  end

endmodule

// File: rtl/light_timer.sv
// Interval countdown timer for the light FSM, one-second ticks.
// Define LIGHT_TIMER_PROG_EN to make tb/te/ty programmable.
module light_timer
  import light_timer_pkg::*;
#(
  parameter int TICK_DIV = 100000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       prog_sync,
  input  logic [1:0] param_sel,
  input  logic [3:0] time_value,
  input  logic [2:0] interval,
  input  logic       start_timer,
  output logic       expired,
  output logic       busy,
  output logic [4:0] remaining
);

  logic [3:0] tb, te, ty;

`ifdef LIGHT_TIMER_PROG_EN
  logic [3:0] tb_q, te_q, ty_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tb_q <= DEF_TB;
      te_q <= DEF_TE;
      ty_q <= DEF_TY;
    end else if (prog_sync) begin
      unique case (1'b1)
        param_sel == PS_BASE:
          tb_q <= (time_value == '0) ? DEF_TB : time_value;
        param_sel == PS_EXT:
          te_q <= (time_value == '0) ? DEF_TE : time_value;
        param_sel == PS_YEL:
          ty_q <= (time_value == '0) ? DEF_TY : time_value;
        default: ;
      endcase
    end
  end

  assign tb = tb_q;
  assign te = te_q;
  assign ty = ty_q;
`else
  logic unused_prog;
  assign unused_prog = ^{prog_sync, param_sel, time_value};
  assign tb = DEF_TB;
  assign te = DEF_TE;
  assign ty = DEF_TY;
`endif

  state_t     state_q, state_d;
  logic [4:0] rem_q, rem_d;
  logic       tick;
  logic       pclr;

  // Prescaler only runs in RUN; a (re)start realigns it.
  assign pclr = start_timer || (state_q != ST_RUN);

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_presc (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (pclr),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    if (start_timer) begin
      state_d = ST_RUN;
      rem_d   = sel_len(interval, tb, te, ty);
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (tick) begin
            rem_d = rem_q - 5'd1;
            if (rem_q == 5'd1)
              state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
          rem_d   = '0;
        end
        default: begin
          state_d = ST_IDLE;
          rem_d   = '0;
        end
      endcase
    end
  end

  assign busy      = (state_q == ST_RUN);
  assign expired   = (state_q == ST_DONE);
  assign remaining = rem_q;

endmodule

// File: doc/light_timer.md
LIGHT_TIMER -- requirements
Module: light_timer

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 100000000, meaning clk cycles per one-second tick (minimum 2).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port prog_sync, input, 1, synchronized one-cycle program strobe.
REQ-005 The block SHALL have port param_sel, input, 2, selects which parameter to program: 0 base, 1 extended, 2 yellow, 3 ignored.
REQ-006 The block SHALL have port time_value, input, 4, new parameter value in seconds.
REQ-007 The block SHALL have port interval, input, 3, interval code from the light FSM: 0 base, 1 double base, 2 extended, 3 yellow, 4-7 treated as base.
REQ-008 The block SHALL have port start_timer, input, 1, one-cycle pulse that (re)starts the countdown.
REQ-009 The block SHALL have port expired, output, 1, one-cycle pulse at the end of the interval.
REQ-010 The block SHALL have port busy, output, 1, high while counting.
REQ-011 The block SHALL have port remaining, output, 5, seconds left in the current interval.

Function
REQ-012 The block SHALL hold three 4-bit parameter registers: tb (default 6), te (default 3), ty (default 2).
REQ-013 On prog_sync with param_sel 0-2, the selected register SHALL load time_value; time_value 0 SHALL load that register's default instead.
REQ-014 The load length SHALL be 5 bits: tb, 2*tb (up to 30, no overflow), te, ty, selected by interval sampled on the start_timer cycle.
REQ-015 The FSM SHALL have states IDLE, RUN and DONE; reset enters IDLE.
REQ-016 IDLE->RUN on start_timer: remaining loads the selected length, prescaler clears, busy rises the next cycle.
REQ-017 In RUN, the prescaler SHALL count 0..TICK_DIV-1 and emit a tick on the terminal count; each tick decrements remaining by 1.
REQ-018 When a tick takes remaining from 1 to 0, the state SHALL go RUN->DONE; in DONE, expired=1 for exactly one cycle, busy=0, then DONE->IDLE.
REQ-019 Expiry latency SHALL be exactly length*TICK_DIV+1 cycles from the start_timer edge to the expired-high cycle.
REQ-020 start_timer in RUN or DONE SHALL restart from the newly selected length; no expired pulse is issued for the aborted interval.
REQ-021 prog_sync during RUN SHALL NOT alter the running count; the new value takes effect at the next start.
REQ-022 prog_sync and start_timer in the same cycle: start SHALL use the pre-update parameter value.
REQ-023 remaining SHALL hold 0 in IDLE and DONE; the prescaler SHALL not run outside RUN.

Reset
REQ-024 On rst_n low, all outputs SHALL go to 0 asynchronously, tb/te/ty SHALL go to defaults, and the state SHALL go to IDLE; an interval in progress is discarded.
REQ-025 Outputs SHALL resume normal behaviour on the first clk edge after rst_n deasserts; no expired pulse may follow reset without a new start_timer.

Configuration
REQ-026 With LIGHT_TIMER_PROG_EN defined, the block SHALL provide the programming logic of REQ-013, REQ-021 and REQ-022.
REQ-027 Without LIGHT_TIMER_PROG_EN, tb/te/ty SHALL be constants at their defaults; prog_sync, param_sel and time_value are ignored, and the ports remain present.

Structure
REQ-028 A shared package light_timer_pkg SHALL hold the interval codes, param_sel codes, default values (6, 3, 2) and the state enum.
REQ-029 The prescaler SHALL be a sub-module tick_prescaler (TICK_DIV parameter, clear input, tick output).

Verification (TICK_DIV=4)
REQ-030 Reset, then start with interval=0 -> busy high, remaining 6..1, expired pulse exactly 25 cycles after start, then IDLE.
REQ-031 prog param_sel=2, value 5, then start with interval=3 -> expires after 5 ticks; prog value 0 -> ty returns to 2.
REQ-032 Start with interval=1, tb=15 programmed -> remaining loads 30, expires after 121 cycles.
REQ-033 Restart when remaining=2 with interval=3 -> reloads 2, no expired for the first interval.
REQ-034 Simultaneous prog (tb=9) and start with interval=0 -> loads 6; the next start loads 9.
REQ-035 rst_n low mid-RUN -> outputs 0 at once, tb back to 6, no expired until a new start.
